// File: rtl/led_pattern_ctrl_if.sv
// Signal bundle between the display-tree logic and the LED pattern controller.
interface led_pattern_ctrl_if #(parameter int CH = 4);
    logic              Strobe16ms;
    logic              PwrOn;
    logic [3*CH-1:0]   ModeReg;
    logic [CH-1:0]     FaultIn;
    logic [CH-1:0]     FaultClr;
    logic              LampTest;
    logic [CH-1:0]     LEDG_N;
    logic [CH-1:0]     LEDR_N;
    logic [CH-1:0]     FaultLatched;
    logic              LampTestBusy;

    modport master (output Strobe16ms, PwrOn, ModeReg, FaultIn, FaultClr, LampTest,
                    input  LEDG_N, LEDR_N, FaultLatched, LampTestBusy);
    modport slave  (input  Strobe16ms, PwrOn, ModeReg, FaultIn, FaultClr, LampTest,
                    output LEDG_N, LEDR_N, FaultLatched, LampTestBusy);
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel bi-colour LED controller: per-channel mode decode, shared blink
// phases, sticky fault flags and a lamp-test sequencer; all outputs registered.
module led_pattern_ctrl #(
    parameter int CH        = 4,
    parameter int FAST_HALF = 8,
    parameter int SLOW_HALF = 32,
    parameter int LT_STEP   = 32
) (
    input  logic              SlowClock,
    input  logic              Reset_N,
    led_pattern_ctrl_if.slave bus
);
    localparam int FW  = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam int SW  = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int STW = (LT_STEP > 1)   ? $clog2(LT_STEP)   : 1;
    localparam int KW  = (CH > 1)        ? $clog2(CH)        : 1;

    typedef enum logic [1:0] {IDLE, ALLG, ALLR, WALK} lt_state_t;

    lt_state_t        state, state_nxt;
    logic [STW-1:0]   step_cnt, step_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [FW-1:0]    fast_cnt;
    logic [SW-1:0]    slow_cnt;
    logic             fast_ph, slow_ph;
    logic [CH-1:0]    fault_q;
    logic [CH-1:0]    g, r, ledg_q, ledr_q;
    logic             busy_q;

    // One phase pair shared by every channel so all blinking LEDs stay in sync.
    always_ff @(posedge SlowClock or negedge Reset_N) begin
        if (!Reset_N) begin
            fast_cnt <= '0;
            slow_cnt <= '0;
            fast_ph  <= 1'b1;
            slow_ph  <= 1'b1;
        end else if (bus.Strobe16ms) begin
            if (fast_cnt == FW'(FAST_HALF-1)) begin
                fast_cnt <= '0;
                fast_ph  <= ~fast_ph;
            end else begin
                fast_cnt <= fast_cnt + 1'b1;
            end
            if (slow_cnt == SW'(SLOW_HALF-1)) begin
                slow_cnt <= '0;
                slow_ph  <= ~slow_ph;
            end else begin
                slow_cnt <= slow_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge SlowClock or negedge Reset_N) begin
        if (!Reset_N) begin
            state    <= IDLE;
            step_cnt <= '0;
            k        <= '0;
            fault_q  <= '0;
            ledg_q   <= '1;
            ledr_q   <= '1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_nxt;
            k        <= k_nxt;
            fault_q  <= bus.FaultIn | (fault_q & ~bus.FaultClr);
            ledg_q   <= ~g;
            ledr_q   <= ~r;
            busy_q   <= (state_nxt != IDLE);
        end
    end

    // A strobe coinciding with the start request is not counted: IDLE never counts.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        k_nxt     = k;
        if (state == IDLE) begin
            if (bus.LampTest && bus.PwrOn) state_nxt = ALLG;
        end else if (!bus.PwrOn) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            k_nxt     = '0;
        end else if (bus.Strobe16ms) begin
            if (step_cnt == STW'(LT_STEP-1)) begin
                step_nxt = '0;
                case (state)
                    ALLG:    state_nxt = ALLR;
                    ALLR:    state_nxt = WALK;
                    default: begin
                        if (k == KW'(CH-1)) begin
                            state_nxt = IDLE;
                            k_nxt     = '0;
                        end else begin
                            k_nxt = k + 1'b1;
                        end
                    end
                endcase
            end else begin
                step_nxt = step_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        g = '0;
        r = '0;
        if (bus.PwrOn) begin
            case (state)
                ALLG: g = '1;
                ALLR: r = '1;
                WALK: begin
                    g[k] = 1'b1;
                    r[k] = 1'b1;
                end
                default: begin
                    for (int i = 0; i < CH; i++) begin
                        case (bus.ModeReg[3*i +: 3])
                            3'b001:  g[i] = 1'b1;
                            3'b010:  r[i] = 1'b1;
                            3'b011:  begin g[i] = 1'b1; r[i] = 1'b1; end
                            3'b100:  g[i] = slow_ph;
                            3'b101:  r[i] = fast_ph;
                            3'b110:  begin g[i] = ~fault_q[i]; r[i] = fault_q[i] & fast_ph; end
                            3'b111:  begin g[i] = slow_ph; r[i] = ~slow_ph; end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.LEDG_N       = ledg_q;
    assign bus.LEDR_N       = ledr_q;
    assign bus.FaultLatched = fault_q;
    assign bus.LampTestBusy = busy_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random traffic, each cycle
// compared against a strobe-counting behavioural model.
module tb_led_pattern_ctrl;
    localparam int CH = 4, FH = 2, SH = 4, LS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_pattern_ctrl_if #(.CH(CH)) bus ();
    led_pattern_ctrl #(.CH(CH), .FAST_HALF(FH), .SLOW_HALF(SH), .LT_STEP(LS)) dut (
        .SlowClock(clk), .Reset_N(rst_n), .bus(bus)
    );

    int n_chk = 0, n_err = 0;
    // Model: total strobes since reset, fault flags, lamp-test strobes since start.
    int            m_str;
    logic [CH-1:0] m_fl;
    bit            m_lt;
    int            m_lts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_str = 0; m_fl = '0; m_lt = 0; m_lts = 0;
    endtask

    task automatic step();
        logic [CH-1:0] eg, er, efl, ng, nr;
        bit fph, sph;
        int pos;
        logic [2:0] md;
        fph = ((m_str / FH) % 2) == 0;
        sph = ((m_str / SH) % 2) == 0;
        eg = '0; er = '0;
        if (bus.PwrOn) begin
            if (m_lt) begin
                pos = m_lts / LS;
                if (pos == 0) eg = '1;
                else if (pos == 1) er = '1;
                else begin eg[pos-2] = 1'b1; er[pos-2] = 1'b1; end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    md = bus.ModeReg[3*c +: 3];
                    case (md)
                        3'd1: eg[c] = 1'b1;
                        3'd2: er[c] = 1'b1;
                        3'd3: begin eg[c] = 1'b1; er[c] = 1'b1; end
                        3'd4: eg[c] = sph;
                        3'd5: er[c] = fph;
                        3'd6: if (m_fl[c]) er[c] = fph; else eg[c] = 1'b1;
                        3'd7: if (sph) eg[c] = 1'b1; else er[c] = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
        efl = bus.FaultIn | (m_fl & ~bus.FaultClr);
        if (m_lt) begin
            if (!bus.PwrOn) m_lt = 0;
            else if (bus.Strobe16ms) begin
                m_lts++;
                if (m_lts == (2 + CH) * LS) m_lt = 0;
            end
        end else if (bus.LampTest && bus.PwrOn) begin
            m_lt = 1; m_lts = 0;
        end
        if (bus.Strobe16ms) m_str++;
        m_fl = efl;
        ng = ~eg; nr = ~er;
        @(posedge clk); #1;
        chk("ledg_n", bus.LEDG_N, ng);
        chk("ledr_n", bus.LEDR_N, nr);
        chk("fault_latched", bus.FaultLatched, m_fl);
        chk("busy", bus.LampTestBusy, m_lt);
    endtask

    task automatic strobes(input int n);
        for (int s = 0; s < n; s++) begin
            bus.Strobe16ms = 1'b1; step();
            bus.Strobe16ms = 1'b0; step();
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ledg_n", bus.LEDG_N, 4'hF);
        chk("rst_ledr_n", bus.LEDR_N, 4'hF);
        chk("rst_fault", bus.FaultLatched, 4'h0);
        chk("rst_busy", bus.LampTestBusy, 1'b0);
    endtask

    initial begin
        bus.Strobe16ms = 0; bus.PwrOn = 0; bus.FaultIn = '0; bus.FaultClr = '0;
        bus.LampTest = 0; bus.ModeReg = {4{3'b001}};
        model_reset();
        #12;
        chk_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        step(); step();
        bus.PwrOn = 1'b1; step();

        // Blink: ch0 fast red, ch1 slow green.
        bus.ModeReg = {3'b001, 3'b001, 3'b100, 3'b101};
        step();
        strobes(16);

        // Fault latch and auto mode on ch2.
        bus.ModeReg[8:6] = 3'b110;
        bus.FaultIn[2] = 1'b1; step();
        bus.FaultIn[2] = 1'b0; step();
        strobes(4);
        bus.FaultIn[2] = 1'b1; bus.FaultClr[2] = 1'b1; step();
        bus.FaultIn[2] = 1'b0; bus.FaultClr[2] = 1'b0; step();
        bus.FaultClr[2] = 1'b1; step();
        bus.FaultClr[2] = 1'b0; step(); step();

        // Full lamp test with an ignored second request.
        bus.LampTest = 1'b1; step();
        bus.LampTest = 1'b0;
        strobes(5);
        bus.LampTest = 1'b1; step();
        bus.LampTest = 1'b0;
        strobes(13);
        step(); step();

        // Power drop during WALK at k=2.
        bus.LampTest = 1'b1; step();
        bus.LampTest = 1'b0;
        strobes(13);
        bus.PwrOn = 1'b0; step(); step();
        bus.PwrOn = 1'b1; step();
        strobes(3);

        // Async reset in ALLR with all faults latched.
        bus.FaultIn = 4'hF; step();
        bus.FaultIn = '0;
        bus.LampTest = 1'b1; step();
        bus.LampTest = 1'b0;
        strobes(4);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step();

        // Random traffic.
        for (int t = 0; t < 600; t++) begin
            bus.ModeReg    = (t % 16 == 0) ? 12'($urandom) : bus.ModeReg;
            bus.FaultIn    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            bus.FaultClr   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.Strobe16ms = ($urandom_range(0, 2) == 0);
            bus.LampTest   = ($urandom_range(0, 30) == 0);
            bus.PwrOn      = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised multi-channel bi-colour LED controller for the CPLD display tree. It replaces per-LED hard-wired decode with per-channel mode codes, a shared blink-rate generator, sticky per-channel fault latching and a lamp-test sequencer. It sits under ODS_MR beside the existing LED logic, clocked from the 32,768 Hz SlowClock, and paced by the existing 16 ms strobe.

## Interface
Parameters:
- CH, 4: number of bi-colour LED channels (1..16).
- FAST_HALF, 8: fast blink half-period, in Strobe16ms ticks (128 ms).
- SLOW_HALF, 32: slow blink half-period, in ticks (512 ms).
- LT_STEP, 32: lamp-test step length, in ticks.

Ports:
- SlowClock  in  1  32,768 Hz clock; the only clock.
- Reset_N  in  1  asynchronous, active-low reset.
- Strobe16ms  in  1  single-SlowClock pulse every 16 ms.
- PwrOn  in  1  1 = power switch on; 0 forces all LEDs off.
- ModeReg  in  3*CH  per-channel mode; channel i uses bits [3i+2:3i].
- FaultIn  in  CH  synchronous fault level per channel.
- FaultClr  in  CH  single-cycle clear request per channel.
- LampTest  in  1  single-cycle lamp-test start request.
- LEDG_N  out  CH  green LED drive, active-low.
- LEDR_N  out  CH  red LED drive, active-low.
- FaultLatched  out  CH  sticky fault flags.
- LampTestBusy  out  1  high while the lamp-test sequence runs.

## Operation
- Blink generator:
  - FastCnt and SlowCnt each advance on Strobe16ms.
  - FastCnt wraps at FAST_HALF-1 and toggles FastPhase on the wrap. SlowCnt wraps at SLOW_HALF-1 and toggles SlowPhase on the wrap.
  - Both phases reset to 1 (lit).
  - One shared phase for all channels, so all LEDs blink in sync. A mode change never resets the phase.
- Mode decode per channel, as {G,R} lit:
  - 000 off.
  - 001 green.
  - 010 red.
  - 011 amber (both).
  - 100 green gated by SlowPhase.
  - 101 red gated by FastPhase.
  - 110 auto: green if FaultLatched[i]=0, else red gated by FastPhase.
  - 111 alternate: green when SlowPhase=1, red when SlowPhase=0.
- Fault latch:
  - FaultLatched[i] sets on any cycle with FaultIn[i]=1.
  - It clears on FaultClr[i]=1 only if FaultIn[i]=0 in the same cycle, so set wins.
  - The latch operates regardless of PwrOn or lamp test.
- Lamp-test FSM states: IDLE, ALLG, ALLR, WALK.
  - IDLE→ALLG on LampTest=1 with PwrOn=1.
  - StepCnt counts strobes. On the strobe where StepCnt=LT_STEP-1, StepCnt returns to 0 and the FSM advances: ALLG→ALLR→WALK.
  - In WALK, index k runs 0..CH-1. Channel k is amber and all other channels are off. k increments at each step end. After k=CH-1 the FSM returns to IDLE.
  - In ALLG every channel is green only; in ALLR every channel is red only.
  - LampTest pulses are ignored outside IDLE.
  - PwrOn=0 in any state returns the FSM to IDLE and clears StepCnt and k.
- Output priority, highest first: PwrOn=0 (all off) > lamp test > mode decode.
- Lit maps to a 0 on LEDG_N/LEDR_N.

## Timing
- All outputs are registered.
- Any input change (mode, PwrOn, FaultIn, phase, FSM state) is reflected on LEDG_N/LEDR_N one SlowClock edge later.
- Path from FaultIn to a mode-110 output: FaultLatched is set at edge n and the LED changes at edge n+1.
- LampTestBusy is high from the edge after the accepted LampTest through the edge on which the FSM re-enters IDLE.
- Lamp-test length is exactly (2+CH)*LT_STEP strobes, measured from the first strobe after start.
- Reset values:
  - LEDG_N and LEDR_N all 1.
  - FaultLatched 0; LampTestBusy 0.
  - FSM in IDLE; StepCnt, k, FastCnt and SlowCnt all 0.
  - FastPhase and SlowPhase 1.
- Reset asserted mid-sequence aborts immediately to the reset values.
- Counter widths are clog2(max value + 1), and no counter ever exceeds its wrap value.
- Strobe16ms arriving in the same cycle as LampTest does not count toward the first step.

## Test plan
Bench parameters: CH=4, FAST_HALF=2, SLOW_HALF=4, LT_STEP=3.
- Release reset with PwrOn=0 and ModeReg=all 001 → LEDG_N=4'hF and LEDR_N=4'hF. Raise PwrOn → LEDG_N=4'h0 one edge later.
- Set ch0 mode 101 and ch1 mode 100, then apply 16 strobes → LEDR_N[0] toggles every 2 strobes and LEDG_N[1] toggles every 4 strobes. Both start lit.
- Set ch2 mode 110 and pulse FaultIn[2] for 1 cycle → FaultLatched=4'b0100 and ch2 blinks red. Pulse FaultClr[2] together with FaultIn[2]=1 → flag stays set. Pulse FaultClr[2] alone → flag clears and ch2 is green.
- Pulse LampTest → Busy=1, then 3 strobes of all green, 3 strobes of all red, then channels 0..3 amber in turn for 3 strobes each. Busy falls after 18 strobes. A second LampTest pulse mid-sequence is ignored.
- Drop PwrOn during WALK at k=2 → all outputs off next edge and Busy=0. Raise PwrOn again → mode decode resumes and no lamp test runs.
- Assert Reset_N low asynchronously in ALLR with FaultLatched=4'hF → all outputs return to reset values without waiting for a clock edge.
